demux_tdm: RTL and testbench
============================

DEMUX_TDM -- requirements
Module: demux_tdm

Interface
REQ-001 Parameter: CANAIS, default 4, number of time slots per frame; only the power-of-two values 2, 4 and 8 are legal.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-004 Port: din  input  1  serial TDM data, one bit per slot per clock.
REQ-005 Port: sync  input  1  frame marker, high during the cycle that carries slot 0.
REQ-006 Port: Y  output  CANAIS  registered demultiplexed word, bit k = slot k of the last complete frame.
REQ-007 Port: valid  output  1  one-cycle pulse, Y was updated on the preceding edge.
REQ-008 Port: S  output  log2(CANAIS)  registered slot index the next sampled din bit is assigned to.
REQ-009 Port: err  output  1  one-cycle pulse on a framing violation.
REQ-010 Port: locked  output  1  high while the FSM is in LOCKED.

Function
REQ-011 The FSM SHALL have exactly two states: HUNT and LOCKED.
REQ-012 In HUNT, din SHALL be ignored while sync=0; S stays 0, Y holds, valid=0.
REQ-013 In HUNT, sync=1 at an edge SHALL store din as slot 0, set S=1 and enter LOCKED.
REQ-014 In LOCKED, each edge SHALL store din into buffer bit S and advance S modulo CANAIS.
REQ-015 On the edge that samples slot CANAIS-1, Y SHALL load {din, buffer[CANAIS-2:0]} and valid SHALL be 1 for the following cycle only.
REQ-016 Latency: the last slot bit reaches Y exactly one edge after being driven; a frame started by sync at edge n yields valid high after edge n+CANAIS-1.
REQ-017 Y SHALL hold its value between valid pulses; partial frames never alter Y.
REQ-018 In LOCKED, sync=1 when S=0 is the expected marker and SHALL raise no error.
REQ-019 In LOCKED, sync=1 when S!=0 SHALL pulse err, discard the partial buffer, store din as slot 0, and set S=1 (resync, stay LOCKED).
REQ-020 In LOCKED, sync=0 when S=0 SHALL pulse err, sample nothing, set S=0 and return to HUNT.
REQ-021 Resync on the slot CANAIS-1 edge (REQ-019) SHALL suppress the Y load and valid for that frame.
REQ-022 err and valid SHALL never be high in the same cycle.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from din or sync to any output.

Reset
REQ-024 When rst=1 at an edge: state=HUNT, Y=0, buffer=0, S=0, valid=0, err=0, locked=0.
REQ-025 rst SHALL take priority over sync and din in the same cycle; a frame in progress is discarded without err.
REQ-026 The first edge with rst=0 SHALL behave as HUNT (sync on that edge is honoured).

Structure
REQ-027 State encodings (HUNT=0, LOCKED=1) and the default CANAIS SHALL live in a shared package/include used by the matching TDM multiplexer transmitter.
REQ-028 The slot counter SHALL be one sub-module, contador_slot (CANAIS-modulo counter with synchronous clear and load-to-1); the rest stays in demux_tdm.

Verification
REQ-029 Reset then sync=1 with din slots 1,0,1,1 (slot0..3) -> valid pulse after 4th edge, Y=4'b1101, locked=1, err=0.
REQ-030 Two back-to-back frames 0,1,1,0 then 1,1,1,1 with sync each slot 0 -> Y=4'b0110 then 4'b1111, valid pulses exactly 4 cycles apart, Y held in between.
REQ-031 Sync re-asserted at slot 2 of a frame -> err pulse that cycle, no valid for the broken frame, next full frame 1,0,0,0 gives Y=4'b0001 with previous Y unchanged until then.
REQ-032 Sync missing at slot 0 after a good frame -> err pulse, locked=0, S=0, Y retains last word, no valid until a new sync.
REQ-033 rst=1 asserted at slot 2 with sync=1 -> next cycle Y=0, S=0, locked=0, valid=0, err=0.
REQ-034 Loopback: transmitter driven with D=4'b1010 and rolling S into demux_tdm -> Y=4'b1010 on every valid.

Source files
------------

// File: rtl/demux_tdm_pkg.sv
// Shared definitions for the TDM multiplexer/demultiplexer pair:
// FSM state encodings and the default number of slots per frame.
package demux_tdm_pkg;

    localparam int CANAIS_DEFAULT = 4;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/demux_tdm_contador_slot.sv
// Slot counter modulo CANAIS with synchronous clear and load-to-1.
// Priority: rst_i, then clr_i, then load1_i, then en_i.
module contador_slot
    import demux_tdm_pkg::*;
#(
    parameter int CANAIS = CANAIS_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      load1_i,
    input  logic                      en_i,
    output logic [$clog2(CANAIS)-1:0] cnt_o
);

    localparam int SW = $clog2(CANAIS);
    localparam logic [SW-1:0] LAST = SW'(CANAIS - 1);

    logic [SW-1:0] cnt_q;
    logic [SW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = SW'(1);
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_tdm.sv
// Serial TDM demultiplexer: locks on the slot-0 sync marker, collects one bit
// per slot and publishes the full frame word with a one-cycle valid pulse.
module demux_tdm
    import demux_tdm_pkg::*;
#(
    parameter int CANAIS = CANAIS_DEFAULT  // legal values: 2, 4, 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      din,
    input  logic                      sync,
    output logic [CANAIS-1:0]         Y,
    output logic                      valid,
    output logic [$clog2(CANAIS)-1:0] S,
    output logic                      err,
    output logic                      locked
);

    localparam int SW = $clog2(CANAIS);
    localparam logic [SW-1:0] LAST = SW'(CANAIS - 1);

    tdm_state_e        state_q;
    logic [CANAIS-2:0] buf_q;
    logic [CANAIS-2:0] buf_d;
    logic [CANAIS-1:0] y_q;
    logic              valid_q;
    logic              err_q;
    logic [SW-1:0]     slot;

    logic resync;
    logic lost;
    logic advance;
    logic frame_end;

    contador_slot #(
        .CANAIS (CANAIS)
    ) u_contador_slot (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (lost),
        .load1_i (sync),
        .en_i    (advance),
        .cnt_o   (slot)
    );

    // Any sync starts a frame at slot 0; in HUNT the slot index is always 0.
    always_comb begin
        resync    = (state_q == LOCKED) && sync && (slot != '0);
        lost      = (state_q == LOCKED) && !sync && (slot == '0);
        advance   = (state_q == LOCKED) && !sync && (slot != '0);
        frame_end = advance && (slot == LAST);
    end

    // The last slot bit goes straight into Y, so the buffer holds CANAIS-1 bits.
    always_comb begin
        buf_d = buf_q;
        if (sync) begin
            buf_d    = '0;
            buf_d[0] = din;
        end else if (advance) begin
            for (int k = 1; k < CANAIS - 1; k++) begin
                if (slot == SW'(k)) begin
                    buf_d[k] = din;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
            buf_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            valid_q <= frame_end;
            err_q   <= resync || lost;
            if (frame_end) begin
                y_q <= {din, buf_q};
            end
            case (state_q)
                HUNT:    if (sync) state_q <= LOCKED;
                LOCKED:  if (lost) state_q <= HUNT;
                default: state_q <= HUNT;
            endcase
        end
    end

    assign Y      = y_q;
    assign valid  = valid_q;
    assign err    = err_q;
    assign S      = slot;
    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_demux_tdm.sv
// Directed bench for demux_tdm (CANAIS=4) with an expected-word scoreboard
// and a behavioural TDM transmitter for the loopback frames.
module tb_demux_tdm;

    localparam int W  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          sync;
    logic [W-1:0]  Y;
    logic          valid;
    logic [SW-1:0] S;
    logic          err;
    logic          locked;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] y_model;
    logic [W-1:0] rnd;
    logic [W-1:0] tx_d;
    logic [SW-1:0] tx_s;

    always #5 clk = ~clk;

    demux_tdm #(
        .CANAIS (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .sync   (sync),
        .Y      (Y),
        .valid  (valid),
        .S      (S),
        .err    (err),
        .locked (locked)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic s, input logic d);
        sync = s;
        din  = d;
        @(posedge clk);
        #1;
    endtask

    // bits[k] is slot k; resync_first marks a sync landing mid-frame.
    task automatic send_frame(input logic [W-1:0] bits, input logic resync_first);
        exp_q.push_back(bits);
        for (int i = 0; i < W; i++) begin
            step(i == 0, bits[i]);
            if (i == 0) begin
                check("slot0_err", err, resync_first);
                check("slot0_locked", locked, 1);
                check("slot0_S", S, 1);
            end
            if (i < W - 1) begin
                check("mid_valid", valid, 0);
                check("mid_Y_hold", Y, y_model);
            end
        end
        check("end_valid", valid, 1);
        check("end_Y", Y, bits);
        check("end_err", err, 0);
        check("end_S", S, 0);
        y_model = bits;
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_valid", valid, 0);
            end else begin
                check("sb_Y", Y, exp_q.pop_front());
            end
        end
        if (rst === 1'b0) begin
            check("err_valid_excl", err & valid, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        sync = 1'b1;
        din  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_Y", Y, 0);
        check("rst_S", S, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_locked", locked, 0);
        y_model = '0;
        rst = 1'b0;

        // slots 1,0,1,1
        send_frame(4'b1101, 1'b0);
        check("f1_locked", locked, 1);

        // back-to-back frames
        send_frame(4'b0110, 1'b0);
        send_frame(4'b1111, 1'b0);

        // sync re-asserted at slot 2
        step(1'b1, 1'b0);
        check("brk_s0_err", err, 0);
        step(1'b0, 1'b1);
        check("brk_S", S, 2);
        send_frame(4'b0001, 1'b1);

        // missing sync at slot 0
        step(1'b0, 1'b1);
        check("lost_err", err, 1);
        check("lost_locked", locked, 0);
        check("lost_S", S, 0);
        check("lost_Y", Y, y_model);
        check("lost_valid", valid, 0);
        step(1'b0, 1'b0);
        check("hunt_err", err, 0);
        check("hunt_locked", locked, 0);
        check("hunt_S", S, 0);
        step(1'b0, 1'b1);
        check("hunt_valid", valid, 0);
        check("hunt_Y", Y, y_model);

        // resync on the last slot suppresses the load
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("last_S", S, 3);
        send_frame(4'b1010, 1'b1);

        // reset mid-frame with sync high
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        check("mrst_Y", Y, 0);
        check("mrst_S", S, 0);
        check("mrst_locked", locked, 0);
        check("mrst_valid", valid, 0);
        check("mrst_err", err, 0);
        rst = 1'b0;
        y_model = '0;
        send_frame(4'b0101, 1'b0);

        repeat (4) begin
            rnd = W'($urandom_range(0, 15));
            send_frame(rnd, 1'b0);
        end

        // loopback from a transmitter with rolling slot index
        tx_d = 4'b1010;
        tx_s = '0;
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(tx_d);
            for (int i = 0; i < W; i++) begin
                sync = (tx_s == '0);
                din  = tx_d[tx_s];
                @(posedge clk);
                #1;
                tx_s = tx_s + 1'b1;
            end
            check("loop_valid", valid, 1);
            check("loop_Y", Y, tx_d);
        end

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
